// File: rtl/fullchip_mc_pkg.sv
// Shared types and constants for the multi-core dispatcher.
package fullchip_mc_pkg;

  localparam int INST_W = 17;

  // Instruction word loaded into a core register when it receives nothing.
  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2
  } mc_state_t;

endpackage

// File: rtl/mc_core.sv
// Minimal PE core: each column accumulates operand lane * instruction weight.
// inst[0] = accumulate, inst[1] = clear, inst[2 +: bw] = weight.
module mc_core
  import fullchip_mc_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INST_W-1:0]       inst,
  input  logic [pr*bw-1:0]        mem_in,
  output logic [col*bw_psum-1:0]  psum
);

  logic [bw-1:0] weight;
  logic          unused_inst_hi;

  assign weight         = inst[2 +: bw];
  assign unused_inst_hi = ^inst[INST_W-1:bw+2];

  for (genvar c = 0; c < col; c++) begin : g_col
    logic [2*bw-1:0]    prod;
    logic [bw_psum-1:0] acc_q;

    assign prod = {{bw{1'b0}}, mem_in[(c % pr)*bw +: bw]} * {{bw{1'b0}}, weight};
    assign psum[c*bw_psum +: bw_psum] = acc_q;

    // Column accumulator; a NOP instruction leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          acc_q <= '0;
      else if (inst[1]) acc_q <= '0;
      else if (inst[0]) acc_q <= acc_q + bw_psum'(prod);
    end
  end

endmodule

// File: rtl/mc_inst_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module mc_inst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = LW'(wr_ptr - rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because pointers gate all reads.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fullchip_mc.sv
// Multi-core instruction dispatcher: queues {core_sel, inst, mem_in} entries
// and issues at most one per cycle to the selected cores' input registers.
// Handshake: an entry transfers on a rising edge where in_valid && in_ready;
// in_valid may be raised independently of in_ready, and in_ready never
// depends on in_valid.
module fullchip_mc
  import fullchip_mc_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 8,
  parameter int ncore   = 2,
  parameter int depth   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [pr*bw-1:0]           mem_in,
  input  logic [INST_W-1:0]          inst,
  input  logic [ncore-1:0]           core_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  input  logic                       flush,
  output logic [$clog2(depth+1)-1:0] fifo_level,
  output logic [ncore-1:0]           issue_sel,
  output logic [15:0]                issued_cnt,
  output logic                       err,
  output logic                       busy
);

  localparam int LW    = $clog2(depth+1);
  localparam int MW    = pr*bw;
  localparam int ENT_W = ncore + INST_W + MW;

  mc_state_t                          state_q, state_d;
  logic                               hold_cnt_q;
  logic                               core_rst_q;
  logic                               push, pop, fifo_clear;
  logic                               fifo_full, fifo_empty;
  logic [ENT_W-1:0]                   head;
  logic [ncore-1:0]                   head_sel;
  logic [INST_W-1:0]                  head_inst;
  logic [MW-1:0]                      head_mem;
  logic [ncore-1:0][INST_W-1:0]       core_inst;
  logic [ncore-1:0][MW-1:0]           core_mem;
  logic [ncore-1:0][col*bw_psum-1:0]  unused_psum;

  assign {head_sel, head_inst, head_mem} = head;
  assign fifo_clear = flush && (state_q == RUN);
  assign busy       = !fifo_empty || (state_q != RUN);

  mc_inst_fifo #(.WIDTH(ENT_W), .DEPTH(depth), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (fifo_clear),
    .push  (push),
    .pop   (pop),
    .din   ({core_sel, inst, mem_in}),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register plus the two-cycle post-reset hold counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_HOLD;
      hold_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= (state_q == RST_HOLD);
    end
  end

  // Next state, handshake and issue decision; flush outranks hold.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      RST_HOLD: if (hold_cnt_q) state_d = RUN;
      RUN: begin
        in_ready = !fifo_full && !flush;
        push     = in_valid && in_ready;
        pop      = !hold && !flush && !fifo_empty;
        if (flush) state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RST_HOLD;
    endcase
  end

  // Core reset: asserted with the chip reset, released entering RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      core_rst_q <= 1'b1;
    else if (state_q == RST_HOLD && state_d == RUN)  core_rst_q <= 1'b0;
  end

  // Issue registers: popped entry goes to selected cores, NOP elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_sel  <= '0;
      issued_cnt <= '0;
      err        <= 1'b0;
      core_inst  <= '0;
      core_mem   <= '0;
    end else begin
      issue_sel <= pop ? head_sel : '0;
      for (int k = 0; k < ncore; k++) begin
        core_inst[k] <= (pop && head_sel[k]) ? head_inst : NOP_INST;
        core_mem[k]  <= (pop && head_sel[k]) ? head_mem  : '0;
      end
      if (pop && head_sel != '0 && issued_cnt != 16'hFFFF)
        issued_cnt <= issued_cnt + 16'd1;
      if (pop && head_sel == '0)
        err <= 1'b1;
    end
  end

  for (genvar k = 0; k < ncore; k++) begin : g_core
    mc_core #(.col(col), .bw(bw), .bw_psum(bw_psum), .pr(pr)) u_core (
      .clk    (clk),
      .rst    (core_rst_q),
      .inst   (core_inst[k]),
      .mem_in (core_mem[k]),
      .psum   (unused_psum[k])
    );
  end

endmodule

// File: tb/tb_fullchip_mc.sv
// Testbench for fullchip_mc: directed scenarios then random traffic, all
// checked against a queue-based behavioural model.
module tb_fullchip_mc;

  localparam int NCORE  = 2;
  localparam int DEPTH  = 4;
  localparam int PR     = 8;
  localparam int BW     = 8;
  localparam int INST_W = 17;
  localparam int MW     = PR*BW;
  localparam int ENT_W  = NCORE + INST_W + MW;

  logic              clk, reset;
  logic [MW-1:0]     mem_in;
  logic [INST_W-1:0] inst;
  logic [NCORE-1:0]  core_sel;
  logic              in_valid, in_ready, hold, flush, err, busy;
  logic [2:0]        fifo_level;
  logic [NCORE-1:0]  issue_sel;
  logic [15:0]       issued_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model state
  logic [ENT_W-1:0]  exp_q[$];
  int                hold_left;
  bit                flushing;
  logic [NCORE-1:0]  exp_sel;
  logic [15:0]       exp_cnt;
  logic              exp_err;
  logic [INST_W-1:0] exp_inst [NCORE];
  logic [MW-1:0]     exp_mem  [NCORE];

  fullchip_mc #(.col(8), .bw(BW), .bw_psum(2*BW+4), .pr(PR), .ncore(NCORE), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_in     (mem_in),
    .inst       (inst),
    .core_sel   (core_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .flush      (flush),
    .fifo_level (fifo_level),
    .issue_sel  (issue_sel),
    .issued_cnt (issued_cnt),
    .err        (err),
    .busy       (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_left = 2;
    flushing  = 1'b0;
    exp_sel   = '0;
    exp_cnt   = '0;
    exp_err   = 1'b0;
    for (int k = 0; k < NCORE; k++) begin
      exp_inst[k] = '0;
      exp_mem[k]  = '0;
    end
  endtask

  task automatic check_outputs();
    bit running;
    running = (hold_left == 0) && !flushing;
    chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
    chk("issue_sel",  64'(issue_sel),  64'(exp_sel));
    chk("issued_cnt", 64'(issued_cnt), 64'(exp_cnt));
    chk("err",        64'(err),        64'(exp_err));
    chk("busy",       64'(busy),       64'((exp_q.size() > 0) || !running));
    for (int k = 0; k < NCORE; k++) begin
      chk($sformatf("core%0d_inst", k), 64'(dut.core_inst[k]), 64'(exp_inst[k]));
      chk($sformatf("core%0d_mem", k),  64'(dut.core_mem[k]),  64'(exp_mem[k]));
    end
  endtask

  // One clock: check in_ready, advance the model, clock, check outputs.
  task automatic tick();
    bit               running, rdy, do_push, do_pop;
    logic [ENT_W-1:0] e;
    logic [NCORE-1:0] s;
    #1;
    running = (hold_left == 0) && !flushing;
    rdy     = running && (exp_q.size() < DEPTH) && !flush;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    do_push = in_valid && rdy;
    do_pop  = running && !hold && !flush && (exp_q.size() > 0);

    exp_sel = '0;
    for (int k = 0; k < NCORE; k++) begin
      exp_inst[k] = '0;
      exp_mem[k]  = '0;
    end
    if (do_pop) begin
      e = exp_q.pop_front();
      s = e[ENT_W-1 -: NCORE];
      exp_sel = s;
      if (s == '0) exp_err = 1'b1;
      else if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      for (int k = 0; k < NCORE; k++) begin
        if (s[k]) begin
          exp_inst[k] = e[MW +: INST_W];
          exp_mem[k]  = e[MW-1:0];
        end
      end
    end
    if (running && flush) exp_q.delete();
    if (do_push) exp_q.push_back({core_sel, inst, mem_in});

    if (hold_left > 0)        hold_left--;
    else if (flushing)        flushing = 1'b0;
    else if (running && flush) flushing = 1'b1;

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("in_ready_rst", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic offer(input logic [NCORE-1:0] sel, input logic [INST_W-1:0] i, input logic [MW-1:0] m);
    in_valid = 1'b1;
    core_sel = sel;
    inst     = i;
    mem_in   = m;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    core_sel = '0; inst = '0; mem_in = '0;
    model_reset();
    #3;

    // Reset release: two cycles not ready, then ready and idle
    do_reset();
    tick(); tick(); tick();

    // Single entry to core1
    offer(2'b10, 17'h00123, 64'h0102_0304_0506_0708);
    tick();
    in_valid = 1'b0;
    tick();
    chk("single_core1_inst", 64'(dut.core_inst[1]), 64'h00123);
    chk("single_core0_inst", 64'(dut.core_inst[0]), 64'h0);
    chk("single_issue_sel",  64'(issue_sel),         64'h2);
    chk("single_issued_cnt", 64'(issued_cnt),        64'd1);
    tick();

    // Backpressure: five offers under hold, four fit
    hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      offer(2'(n % 3 + 1), INST_W'(17'h100 + n), {2{32'(n * 32'h1111)}});
      tick();
    end
    chk("bp_level_full", 64'(fifo_level), 64'd4);
    in_valid = 1'b0;
    hold     = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    tick();

    // Zero mask then broadcast
    offer(2'b00, 17'h0AAAA, 64'hDEAD_BEEF_0000_0001);
    tick();
    offer(2'b11, 17'h15555, 64'hCAFE_F00D_1234_5678);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("zero_err", 64'(err), 64'd1);
    chk("bcast_core0_inst", 64'(dut.core_inst[0]), 64'h0);
    tick();

    // Flush with three queued under hold
    hold = 1'b1;
    for (int n = 0; n < 3; n++) begin
      offer(2'b01, INST_W'(17'h200 + n), 64'(n));
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    chk("flush_level", 64'(fifo_level), 64'd0);
    flush = 1'b0;
    tick(); tick();
    hold = 1'b0;
    tick();

    // Mid-operation reset with two queued
    hold = 1'b1;
    for (int n = 0; n < 2; n++) begin
      offer(2'b11, INST_W'(17'h300 + n), 64'(n + 7));
      tick();
    end
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 5; n++) tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      hold     = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      core_sel = NCORE'($urandom_range(0, 3));
      inst     = INST_W'($urandom);
      mem_in   = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    for (int n = 0; n < 8; n++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fullchip_mc.md
FULLCHIP_MC -- requirements
Module: fullchip_mc

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  col  8  PE columns per core
  bw  8  operand width
  bw_psum  2*bw+4  partial-sum width
  pr  8  operand lanes per mem_in word
  ncore  2  number of core instances, 1..8
  depth  4  dispatch FIFO entries, power of two, >=2
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset; asserted when 0
  mem_in  in  pr*bw  operand word for the entry
  inst  in  17  core instruction for the entry
  core_sel  in  ncore  one-hot or multi-hot target mask
  in_valid  in  1  entry offered
  in_ready  out  1  entry accepted when in_valid&in_ready
  hold  in  1  pause issue; FIFO still accepts
  flush  in  1  synchronous FIFO clear
  fifo_level  out  $clog2(depth+1)  occupied entries
  issue_sel  out  ncore  mask of entry issued last cycle, else 0
  issued_cnt  out  16  issued-entry count, saturating
  err  out  1  sticky: zero-mask entry popped
  busy  out  1  FIFO non-empty or not in RUN

Function
REQ-003 The block SHALL instantiate ncore core instances with parameters col, bw, bw_psum, pr, each fed by a per-core registered inst (17b) and mem_in (pr*bw) pair.
REQ-004 States SHALL be RST_HOLD, RUN, FLUSH; RST_HOLD is entered on reset, lasts 2 cycles after reset release, then RUN.
REQ-005 Core resets SHALL be active-high, asserted asynchronously while reset=0, deasserted synchronously at the RST_HOLD->RUN edge.
REQ-006 in_ready SHALL equal (state==RUN) & !full & !flush, combinationally.
REQ-007 An accepted entry {core_sel, inst, mem_in} SHALL be written to the FIFO tail at that edge.
REQ-008 Issue: in RUN with hold=0, flush=0 and FIFO non-empty, the head SHALL pop at the edge; per-core registers load inst/mem_in where core_sel[k]=1 and 0 elsewhere.
REQ-009 In any cycle without issue, all per-core inst/mem_in registers SHALL load 0 (NOP).
REQ-010 Latency: entry accepted at edge N into an empty FIFO SHALL appear at the core inputs and on issue_sel after edge N+1; one issue per cycle max.
REQ-011 Simultaneous push and pop SHALL leave fifo_level unchanged; a push when full is impossible (in_ready=0); a pop when empty is a no-op.
REQ-012 A popped entry with core_sel=0 SHALL be discarded: err set (sticky until reset), issue_sel=0, issued_cnt unchanged.
REQ-013 issued_cnt SHALL increment by 1 per non-discarded issue and hold at 16'hFFFF.
REQ-014 flush=1 in RUN SHALL move to FLUSH for 1 cycle: FIFO emptied at that edge, no push, no pop, NOP issued; FLUSH returns to RUN next cycle; flush takes priority over hold.
REQ-015 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-016 On reset=0, asynchronously: state=RST_HOLD, FIFO empty, fifo_level=0, issue_sel=0, issued_cnt=0, err=0, per-core registers 0, in_ready=0, busy=1.
REQ-017 Reset mid-operation SHALL discard all queued entries; no partial issue follows release.

Structure
REQ-018 Package fullchip_mc_pkg SHALL hold INST_W=17, the state enum, and the NOP instruction constant.
REQ-019 One sub-module, mc_inst_fifo, SHALL implement the synchronous FIFO (width, depth parameters; push, pop, level, full, empty).

Verification
REQ-020 Reset release: reset 0->1 -> in_ready=0 for 2 cycles, then 1; busy=0, fifo_level=0.
REQ-021 Single entry: inst=17'h00123, core_sel=2'b10 accepted at edge N -> after N+1 core1 inst=17'h00123, core0 inst=0, issue_sel=2'b10, issued_cnt=1.
REQ-022 Backpressure: hold=1, push 5 entries with depth=4 -> 4 accepted, in_ready=0, fifo_level=4; release hold -> 4 issues on consecutive cycles in order, fifo_level 3,2,1,0.
REQ-023 Zero mask: entry core_sel=0 then core_sel=2'b11 -> err=1, issued_cnt=1, both cores receive second inst.
REQ-024 Flush: 3 queued, hold=1, flush pulse -> fifo_level=0 next cycle, no issue, in_ready=0 during flush cycle only.
REQ-025 Mid-op reset: 2 queued, reset=0 for 1 cycle -> all outputs at reset values immediately, no issue after release.
